// File: rtl/vn_pkg.sv
// Shared types and saturating-arithmetic helpers for the LDPC variable-node accumulator.
package vn_pkg;

  localparam int LLR_W = 6;
  localparam logic [LLR_W-1:0] LLR_MAX = 6'b011111;
  localparam logic [LLR_W-1:0] LLR_MIN = 6'b100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    XOUT  = 2'd3
  } state_e;

  // Returns {overflow, saturated result}; overflow is judged from the operand and sum sign bits.
  function automatic logic [LLR_W:0] sat_add(input logic [LLR_W-1:0] a,
                                             input logic [LLR_W-1:0] b,
                                             input logic [LLR_W-1:0] sum);
    logic             ovf;
    logic [LLR_W-1:0] res;
    ovf = (a[LLR_W-1] == b[LLR_W-1]) && (sum[LLR_W-1] != a[LLR_W-1]);
    if (ovf) begin
      res = a[LLR_W-1] ? LLR_MIN : LLR_MAX;
    end else begin
      res = sum;
    end
    return {ovf, res};
  endfunction

  // Two's-complement negate where -(-32) clamps to +31.
  function automatic logic [LLR_W-1:0] sat_neg(input logic [LLR_W-1:0] m);
    logic [LLR_W-1:0] res;
    if (m == LLR_MIN) begin
      res = LLR_MAX;
    end else begin
      res = ~m + 6'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// W-bit ripple-carry adder; carry-out is not produced, callers detect overflow from sign bits.
module ripple_adder #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ carry_s[i];
    if (i < W - 1) begin : g_carry
      assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/vn_accumulator.sv
// Serial LDPC variable-node update: channel LLR plus DEG check messages, saturated, with hard decision.
// Optional extrinsic output stream is enabled by defining VN_EXTRINSIC_EN.
module vn_accumulator
  import vn_pkg::*;
#(
  parameter int DEG = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LLR_W-1:0] llr_i,
  input  logic             msg_valid_i,
  input  logic [LLR_W-1:0] msg_i,
  output logic             msg_ready_o,
  output logic             app_valid_o,
  output logic [LLR_W-1:0] app_o,
  output logic             hard_o,
  input  logic             app_ready_i,
  output logic             sat_o,
`ifdef VN_EXTRINSIC_EN
  output logic             ext_valid_o,
  output logic [LLR_W-1:0] ext_o,
  input  logic             ext_ready_i,
`endif
  output logic             busy_o
);

  localparam int CNT_W = $clog2(DEG + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEG - 1);

  state_e           state_r;
  state_e           state_s;
  logic [LLR_W-1:0] acc_r;
  logic [LLR_W-1:0] app_r;
  logic [LLR_W-1:0] acc_sum_s;
  logic [LLR_W-1:0] acc_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             acc_ovf_s;
  logic             accept_s;
  logic             last_s;
  logic             hard_r;
  logic             sat_r;
  logic             msg_ready_r;
  logic             app_valid_r;
  logic             busy_r;

  ripple_adder #(.W(LLR_W)) u_acc_add (
    .a   (acc_r),
    .b   (msg_i),
    .cin (1'b0),
    .sum (acc_sum_s)
  );

  assign {acc_ovf_s, acc_next_s} = sat_add(acc_r, msg_i, acc_sum_s);
  assign accept_s = msg_valid_i && msg_ready_r && (state_r == ACCUM);
  assign last_s   = (cnt_r == LAST);

`ifdef VN_EXTRINSIC_EN
  logic [LLR_W-1:0] msg_buf_r [DEG];
  logic [CNT_W-1:0] ext_idx_r;
  logic [CNT_W-1:0] ext_sel_s;
  logic [LLR_W-1:0] ext_neg_s;
  logic [LLR_W-1:0] ext_sum_s;
  logic [LLR_W-1:0] ext_next_s;
  logic [LLR_W-1:0] ext_r;
  logic             ext_valid_r;
  logic             ext_last_s;

  // Entry 0 is pre-computed during the APP hand-off, later entries one beat ahead.
  assign ext_last_s = (ext_idx_r == LAST);
  assign ext_sel_s  = ((state_r == XOUT) && !ext_last_s) ? (ext_idx_r + CNT_W'(1)) : {CNT_W{1'b0}};
  assign ext_neg_s  = sat_neg(msg_buf_r[ext_sel_s]);

  ripple_adder #(.W(LLR_W)) u_ext_add (
    .a   (app_r),
    .b   (ext_neg_s),
    .cin (1'b0),
    .sum (ext_sum_s)
  );

  assign ext_next_s  = LLR_W'(sat_add(app_r, ext_neg_s, ext_sum_s));
  assign ext_valid_o = ext_valid_r;
  assign ext_o       = ext_r;
`endif

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && last_s) begin
          state_s = DONE;
        end else begin
          state_s = ACCUM;
        end
      end
      DONE: begin
        if (app_ready_i) begin
`ifdef VN_EXTRINSIC_EN
          state_s = XOUT;
`else
          state_s = IDLE;
`endif
        end else begin
          state_s = DONE;
        end
      end
`ifdef VN_EXTRINSIC_EN
      XOUT: begin
        if (ext_ready_i && ext_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = XOUT;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // State register and handshake flags, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      msg_ready_r <= 1'b0;
      app_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      msg_ready_r <= (state_s == ACCUM);
      app_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Accumulator, message counter, sticky saturation and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {LLR_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      sat_r  <= 1'b0;
      app_r  <= {LLR_W{1'b0}};
      hard_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && start_i) begin
        acc_r <= llr_i;
        cnt_r <= {CNT_W{1'b0}};
        sat_r <= 1'b0;
      end else if (accept_s) begin
        acc_r <= acc_next_s;
        cnt_r <= cnt_r + CNT_W'(1);
        sat_r <= sat_r | acc_ovf_s;
        if (last_s) begin
          app_r  <= acc_next_s;
          hard_r <= acc_next_s[LLR_W-1];
        end
      end
    end
  end

`ifdef VN_EXTRINSIC_EN
  // Message buffer and extrinsic output stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEG; k++) begin
        msg_buf_r[k] <= {LLR_W{1'b0}};
      end
      ext_idx_r   <= {CNT_W{1'b0}};
      ext_r       <= {LLR_W{1'b0}};
      ext_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        msg_buf_r[cnt_r] <= msg_i;
      end
      if ((state_r == DONE) && app_ready_i) begin
        ext_idx_r   <= {CNT_W{1'b0}};
        ext_r       <= ext_next_s;
        ext_valid_r <= 1'b1;
      end else if ((state_r == XOUT) && ext_ready_i) begin
        if (ext_last_s) begin
          ext_valid_r <= 1'b0;
        end else begin
          ext_idx_r <= ext_idx_r + CNT_W'(1);
          ext_r     <= ext_next_s;
        end
      end
    end
  end
`endif

  assign msg_ready_o = msg_ready_r;
  assign app_valid_o = app_valid_r;
  assign app_o       = app_r;
  assign hard_o      = hard_r;
  assign sat_o       = sat_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_vn_accumulator.sv
// Self-checking bench for vn_accumulator: scoreboard of expected APP results (and extrinsic beats when enabled).
module tb_vn_accumulator;

  localparam int DEG = 6;

  typedef logic [5:0] msg_arr_t [DEG];
  typedef struct {
    logic [5:0] app;
    logic       hard;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [5:0] llr_i;
  logic       msg_valid_i;
  logic [5:0] msg_i;
  logic       msg_ready_o;
  logic       app_valid_o;
  logic [5:0] app_o;
  logic       hard_o;
  logic       app_ready_i;
  logic       sat_o;
  logic       busy_o;
`ifdef VN_EXTRINSIC_EN
  logic       ext_valid_o;
  logic [5:0] ext_o;
  logic       ext_ready_i;
`endif

  exp_t       sb_q[$];
  logic [5:0] ext_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  vn_accumulator #(.DEG(DEG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .llr_i       (llr_i),
    .msg_valid_i (msg_valid_i),
    .msg_i       (msg_i),
    .msg_ready_o (msg_ready_o),
    .app_valid_o (app_valid_o),
    .app_o       (app_o),
    .hard_o      (hard_o),
    .app_ready_i (app_ready_i),
    .sat_o       (sat_o),
`ifdef VN_EXTRINSIC_EN
    .ext_valid_o (ext_valid_o),
    .ext_o       (ext_o),
    .ext_ready_i (ext_ready_i),
`endif
    .busy_o      (busy_o)
  );

  function automatic int clamp6(input int v);
    if (v > 31) return 31;
    else if (v < -32) return -32;
    else return v;
  endfunction

  // Pushes the expected result, then starts an update and feeds DEG messages.
  task automatic drive_update(input logic [5:0] llr, input msg_arr_t m, input bit gaps, input bit want_ext);
    int e;
    int nv;
    int k;
    int guard;
    bit s;
    guard = 0;
    while (busy_o === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: busy_o=%b required 0", busy_o);
    end
    e = $signed(llr);
    s = 1'b0;
    for (int i = 0; i < DEG; i++) begin
      e = e + int'($signed(m[i]));
      if (e != clamp6(e)) s = 1'b1;
      e = clamp6(e);
    end
    sb_q.push_back('{6'(e), (e < 0), s});
    if (want_ext) begin
      for (int i = 0; i < DEG; i++) begin
        nv = (m[i] == 6'b100000) ? 31 : -int'($signed(m[i]));
        ext_q.push_back(6'(clamp6(e + nv)));
      end
    end
    llr_i   = llr;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    guard = 0;
    while (k < DEG && guard < 200) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        msg_valid_i = 1'b0;
        msg_i       = 6'($urandom);
      end else begin
        msg_valid_i = 1'b1;
        msg_i       = m[k];
        if (msg_ready_o === 1'b1) k++;
      end
      @(negedge clk);
      guard++;
    end
    msg_valid_i = 1'b0;
    n_checks++;
    if (k != DEG) begin
      n_fail++;
      $display("FAIL msg_accept: accepted %0d required %0d", k, DEG);
    end
  endtask

  task automatic wait_app();
    int g;
    g = 0;
    while (app_valid_o !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic handoff();
    app_ready_i = 1'b1;
    @(negedge clk);
    app_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({msg_ready_o, app_valid_o, busy_o, sat_o, hard_o, app_o} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {msg_ready_o, app_valid_o, busy_o, sat_o, hard_o, app_o});
    end
    rst_n       = 1'b1;
    msg_valid_i = 1'b1;
    msg_i       = 6'd5;
    repeat (2) @(negedge clk);
    n_checks++;
    if (msg_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_msg_ignored: msg_ready_o=%b required 0", msg_ready_o);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: busy_o=%b required 0", busy_o);
    end
    msg_valid_i = 1'b0;
  endtask

  task automatic test_basic();
    msg_arr_t m;
    exp_t     ex;
    m = '{6'd1, 6'd2, 6'h3c, 6'd5, 6'd0, 6'h3f};
    drive_update(6'd3, m, 1'b0, 1'b0);
    n_checks++;
    if (app_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: app_valid_o=%b required 1 one cycle after last accept", app_valid_o);
    end
    ex = sb_q.pop_front();
    n_checks++;
    if (app_o !== ex.app) begin
      n_fail++;
      $display("FAIL basic_app: app_o=%0d required %0d", $signed(app_o), $signed(ex.app));
    end
    n_checks++;
    if (hard_o !== ex.hard || sat_o !== ex.sat) begin
      n_fail++;
      $display("FAIL basic_flags: hard/sat=%b%b required %b%b", hard_o, sat_o, ex.hard, ex.sat);
    end
    handoff();
  endtask

  task automatic test_saturation();
    msg_arr_t m;
    exp_t     ex;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) m = '{6'd5, 6'd5, 6'h36, 6'd0, 6'd0, 6'd0};
      else        m = '{6'h38, 6'h38, 6'h38, 6'h38, 6'h38, 6'h38};
      drive_update((t == 0) ? 6'd30 : 6'h22, m, 1'b0, 1'b0);
      wait_app();
      ex = sb_q.pop_front();
      n_checks++;
      if (app_o !== ex.app) begin
        n_fail++;
        $display("FAIL sat%0d_app: app_o=%0d required %0d", t, $signed(app_o), $signed(ex.app));
      end
      n_checks++;
      if (hard_o !== ex.hard) begin
        n_fail++;
        $display("FAIL sat%0d_hard: hard_o=%b required %b", t, hard_o, ex.hard);
      end
      n_checks++;
      if (sat_o !== ex.sat) begin
        n_fail++;
        $display("FAIL sat%0d_sticky: sat_o=%b required %b", t, sat_o, ex.sat);
      end
      handoff();
    end
  endtask

  task automatic test_hold();
    msg_arr_t m;
    exp_t     ex;
    m = '{6'd7, 6'h3d, 6'd4, 6'd9, 6'h30, 6'd2};
    drive_update(6'h3e, m, 1'b0, 1'b0);
    wait_app();
    ex = sb_q.pop_front();
    for (int c = 0; c < 3; c++) begin
      start_i = (c == 1);
      n_checks++;
      if (app_valid_o !== 1'b1 || app_o !== ex.app) begin
        n_fail++;
        $display("FAIL hold_app: valid=%b app_o=%0d required 1 and %0d", app_valid_o, $signed(app_o), $signed(ex.app));
      end
      n_checks++;
      if (msg_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_ready: msg_ready_o=%b required 0", msg_ready_o);
      end
      @(negedge clk);
    end
    app_ready_i = 1'b1;
    start_i     = 1'b1;
    @(negedge clk);
    app_ready_i = 1'b0;
    start_i     = 1'b0;
    n_checks++;
    if (app_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: app_valid_o=%b required 0", app_valid_o);
    end
`ifndef VN_EXTRINSIC_EN
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_restart: busy_o=%b required 0", busy_o);
    end
`endif
    repeat (DEG + 2) @(negedge clk);
    n_checks++;
    if (msg_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: msg_ready_o=%b busy_o=%b required 0 0", msg_ready_o, busy_o);
    end
  endtask

  task automatic test_abort();
    msg_arr_t m;
    exp_t     ex;
    llr_i   = 6'd5;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      msg_valid_i = 1'b1;
      msg_i       = 6'd7;
      @(negedge clk);
    end
    msg_valid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({msg_ready_o, app_valid_o, busy_o, sat_o, hard_o, app_o} !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b required 0", {msg_ready_o, app_valid_o, busy_o, sat_o, hard_o, app_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    m = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    drive_update(6'd0, m, 1'b0, 1'b0);
    wait_app();
    ex = sb_q.pop_front();
    n_checks++;
    if (app_o !== ex.app || sat_o !== ex.sat || hard_o !== ex.hard) begin
      n_fail++;
      $display("FAIL abort_restart: app=%0d sat=%b hard=%b required %0d %b %b",
               $signed(app_o), sat_o, hard_o, $signed(ex.app), ex.sat, ex.hard);
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    msg_arr_t m;
    exp_t     ex;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < DEG; i++) m[i] = 6'($urandom);
      drive_update(6'($urandom), m, 1'b1, 1'b0);
      wait_app();
      ex = sb_q.pop_front();
      n_checks++;
      if (app_o !== ex.app || hard_o !== ex.hard) begin
        n_fail++;
        $display("FAIL b2b%0d_app: app_o=%0d hard=%b required %0d %b", t, $signed(app_o), hard_o, $signed(ex.app), ex.hard);
      end
      n_checks++;
      if (sat_o !== ex.sat) begin
        n_fail++;
        $display("FAIL b2b%0d_sat: sat_o=%b required %b", t, sat_o, ex.sat);
      end
      handoff();
    end
  endtask

`ifdef VN_EXTRINSIC_EN
  task automatic test_extrinsic();
    msg_arr_t   m;
    exp_t       ex;
    logic [5:0] ev;
    logic [5:0] held_val;
    bit         held;
    int         beats;
    int         guard;
    m = '{6'd1, 6'd2, 6'h3c, 6'd5, 6'd0, 6'h3f};
    ext_ready_i = 1'b0;
    drive_update(6'd3, m, 1'b0, 1'b1);
    wait_app();
    ex = sb_q.pop_front();
    n_checks++;
    if (app_o !== ex.app) begin
      n_fail++;
      $display("FAIL ext_app: app_o=%0d required %0d", $signed(app_o), $signed(ex.app));
    end
    handoff();
    beats    = 0;
    guard    = 0;
    held     = 1'b0;
    held_val = 6'd0;
    while (beats < DEG && guard < 200) begin
      if (ext_valid_o === 1'b1) begin
        if (held) begin
          n_checks++;
          if (ext_o !== held_val) begin
            n_fail++;
            $display("FAIL ext_hold: ext_o=%0d required %0d", $signed(ext_o), $signed(held_val));
          end
        end
        if ($urandom_range(0, 1) == 1) begin
          ext_ready_i = 1'b1;
          ev = ext_q.pop_front();
          n_checks++;
          if (ext_o !== ev) begin
            n_fail++;
            $display("FAIL ext_beat%0d: ext_o=%0d required %0d", beats, $signed(ext_o), $signed(ev));
          end
          beats++;
          held = 1'b0;
        end else begin
          ext_ready_i = 1'b0;
          held        = 1'b1;
          held_val    = ext_o;
        end
      end else begin
        ext_ready_i = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    ext_ready_i = 1'b1;
    n_checks++;
    if (beats != DEG) begin
      n_fail++;
      $display("FAIL ext_count: beats=%0d required %0d", beats, DEG);
    end
    n_checks++;
    if (ext_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_end: ext_valid_o=%b busy_o=%b required 0 0", ext_valid_o, busy_o);
    end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    llr_i       = 6'd0;
    msg_valid_i = 1'b0;
    msg_i       = 6'd0;
    app_ready_i = 1'b0;
`ifdef VN_EXTRINSIC_EN
    ext_ready_i = 1'b1;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_hold();
    test_abort();
    test_back_to_back();
`ifdef VN_EXTRINSIC_EN
    test_extrinsic();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
